// File: rtl/ubitstream_decoder.sv
// Unary bitstream decoder: counts 1s over a window of 2^WINDOW_LOG2 enabled samples.
// Optional macro UBITSTREAM_DECODER_BIPOLAR_EN selects two's-complement bipolar output.
module ubitstream_decoder #(
   parameter int BITWIDTH    = 8,
   parameter int WINDOW_LOG2 = BITWIDTH
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iEn,
   input  logic                iClr,
   input  logic                iStart,
   input  logic                iBit,
   output logic [BITWIDTH-1:0] oBin,
   output logic                oValid,
   output logic                oBusy
);

   localparam int SHIFT = BITWIDTH - WINDOW_LOG2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WINDOW_LOG2-1:0] r_cnt;
   logic [WINDOW_LOG2-1:0] w_cnt_nxt;
   logic [WINDOW_LOG2:0]   r_acc;
   logic [WINDOW_LOG2:0]   w_acc_nxt;
   logic [WINDOW_LOG2:0]   w_acc_inc;
   logic [BITWIDTH-1:0]    r_bin;
   logic [BITWIDTH-1:0]    w_bin_nxt;
   logic                   r_valid;
   logic                   w_valid_nxt;
   logic                   r_busy;

   // Scale the ones count to BITWIDTH; only an all-ones window overflows and saturates.
   function automatic logic [BITWIDTH-1:0] f_result(input logic [WINDOW_LOG2:0] n);
      logic [BITWIDTH:0]   w_scaled;
      logic [BITWIDTH-1:0] w_res;
      w_scaled = (BITWIDTH+1)'(n) << SHIFT;
      if (w_scaled[BITWIDTH]) begin
         w_res = '1;
      end else begin
         w_res = w_scaled[BITWIDTH-1:0];
      end
`ifdef UBITSTREAM_DECODER_BIPOLAR_EN
      w_res[BITWIDTH-1] = ~w_res[BITWIDTH-1];
`endif
      return w_res;
   endfunction

   assign w_acc_inc = r_acc + {{WINDOW_LOG2{1'b0}}, iBit};

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      w_bin_nxt   = r_bin;
      w_valid_nxt = 1'b0;
      if (iClr) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_acc_nxt   = '0;
         w_bin_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (iStart) begin
                  w_state_nxt = ST_ACC;
                  w_cnt_nxt   = '0;
                  w_acc_nxt   = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_ACC: begin
               if (iEn) begin
                  if (r_cnt == '1) begin
                     // Final sample: publish and either restart or go idle.
                     w_bin_nxt   = f_result(w_acc_inc);
                     w_valid_nxt = 1'b1;
                     w_cnt_nxt   = '0;
                     w_acc_nxt   = '0;
                     if (iStart) begin
                        w_state_nxt = ST_ACC;
                     end else begin
                        w_state_nxt = ST_IDLE;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + WINDOW_LOG2'(1);
                     w_acc_nxt = w_acc_inc;
                  end
               end else begin
                  w_state_nxt = ST_ACC;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_acc_nxt   = '0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_bin   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_acc   <= w_acc_nxt;
         r_bin   <= w_bin_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= (w_state_nxt == ST_ACC);
      end
   end

   assign oBin   = r_bin;
   assign oValid = r_valid;
   assign oBusy  = r_busy;

endmodule
